m6810_ram_arbiter: RTL and testbench
====================================

# m6810_ram_arbiter

Arbiter and initialiser for the 128×8 sound-board scratch RAM. It shares one RAM port between the 6800 CPU and a host/debug port (loader or scope). After reset it zero-fills the RAM before granting anyone access. It sits between the CPU address decode and the RAM instance.

## Interface
Parameters:
- `STARVE_LIMIT`, default 15: host wait cycles before `cpu_wait` is raised.
- `RAM_DEPTH`, default 128: words to clear; fixed at 128 in this design.

Ports:
- `clk` in 1: single clock for the block.
- `rst` in 1: reset, asynchronous, active-high.
- `clr_req` in 1: one-cycle pulse that restarts the zero-fill.
- `cpu_address` in 7, `cpu_cs` in 1, `cpu_rw` in 1 (1 = read), `cpu_wdata` in 8: CPU RAM access.
- `cpu_rdata` out 8: CPU read data.
- `cpu_wait` out 1: request to halt the CPU.
- `host_req` in 1, `host_rw` in 1, `host_address` in 7, `host_wdata` in 8: host request, held stable until ack.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out 8: registered host read data.
- `busy` out 1: high while clearing.
- `ram_address` out 7, `ram_cs` out 1, `ram_rw` out 1, `ram_wdata` out 8: to the RAM.
- `ram_rdata` in 8: combinational RAM read data.

## Operation
States:
- CLEAR: entered on `rst` or `clr_req`. Drives `ram_cs`=1, `ram_rw`=0, `ram_wdata`=0, `ram_address`=`clr_cnt`. Increments `clr_cnt` once per cycle from 0 to 127. Goes to IDLE after writing address 127, i.e. 128 write cycles. In CLEAR:
  - `busy`=1 and `cpu_wait`=1.
  - `cpu_rdata`=0x00.
  - CPU writes are dropped.
  - Host requests are held; no ack is given.
- IDLE:
  - CPU priority: if `cpu_cs`=1, the RAM port is driven from the CPU signals in the same cycle (combinational mux), and `cpu_rdata`=`ram_rdata`.
  - Host grant: if `cpu_cs`=0, `host_req`=1, and no ack is pending, drive the RAM from the host signals for that cycle. Latch `ram_rdata` into `host_rdata` on reads (unchanged on writes), and go to ACK.
  - If neither requests, `ram_cs`=0.
- ACK: `host_ack`=1 for exactly one cycle. The CPU may still access RAM in this cycle. No host grant is made in ACK, so a `host_req` still held during ack is not re-granted. Return to IDLE.

Other rules:
- Starvation counter: 4-bit `wait_cnt`.
  - Increments each cycle that `host_req`=1, state is IDLE, and the host is not granted; saturates.
  - Cleared on host grant or when `host_req`=0.
  - In IDLE, `cpu_wait`=1 while `wait_cnt` ≥ `STARVE_LIMIT`. `cpu_wait` is advisory; CPU priority is never overridden.
- `clr_req` in any state aborts the current activity and enters CLEAR with `clr_cnt`=0. A pending host ack is cancelled; the host stays held.
- `cpu_rdata` is `ram_rdata` whenever not in CLEAR; it is only meaningful while `cpu_cs`=1.

## Timing
- Reset values: state CLEAR, `clr_cnt`=0, `wait_cnt`=0, `host_ack`=0, `host_rdata`=0x00, `busy`=1, `cpu_wait`=1.
- The first clear write happens in the first cycle after `rst` deasserts. `busy` falls after 128 cycles.
- CPU access: zero added latency, fully combinational path through the mux.
- Host latency: the grant cycle is G, `host_ack`=1 in cycle G+1, and `host_rdata` is valid from G+1 until the next host read.
- Host back-to-back accesses: at most one every 2 cycles.
- Simultaneous `cpu_cs` and `host_req`: the CPU wins and the host waits.
- `clr_req` in the same cycle as a host grant: the clear wins and no RAM write from the host occurs.
- `rst` mid-operation: immediate asynchronous return to reset values.

## Structure
- Shared package `robotron_snd_pkg` holds:
  - a state enum with CLEAR, IDLE and ACK;
  - the `RAM_DEPTH` and `RAM_AW`=7 constants.
- One sub-module, `ram_clear_seq`, is natural: it holds the 7-bit counter with start/done, is used by CLEAR, and can be reused for other board RAMs.
- The arbitration mux and the ACK FSM stay in the top module.

## Test plan
- Reset, then hold idle: `busy`=1 for 128 cycles, addresses 0..127 are written with 0x00, then `busy`=0 and a CPU read of 0x45 returns 0x00.
- CPU write 0x5A to 0x10, then read: `cpu_rdata`=0x5A in the same cycle, with no wait states.
- Host write 0xC3 to 0x7F with `cpu_cs`=0: `host_ack` pulses 1 cycle later. A host read of 0x7F then gives `host_rdata`=0xC3 at the ack.
- `cpu_cs`=1 continuously with `host_req`=1: no host grant; `cpu_wait` rises after 15 cycles. When `cpu_cs` drops, the host is granted the next cycle and `cpu_wait` falls.
- `clr_req` pulse at `clr_cnt`=50 during CLEAR: the counter restarts at 0, and `busy` lasts a further 128 cycles.
- Host request held through the ack cycle: only one RAM write occurs and exactly one `host_ack` is given.

Source files
------------

// File: rtl/robotron_snd_pkg.sv
// Shared types and constants for the sound-board RAM glue.
package robotron_snd_pkg;

   localparam int RAM_DEPTH = 128;
   localparam int RAM_AW    = 7;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      ACK   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Address sequencer for zero-filling a RAM: restarts at 0 on start, steps while run.
// done flags the last address so the caller can leave its clear phase that cycle.
module ram_clear_seq
   import robotron_snd_pkg::*;
#(
   parameter int DEPTH = RAM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              run,
   output logic [RAM_AW-1:0] cnt,
   output logic              done
);

   localparam logic [RAM_AW-1:0] LAST = RAM_AW'(DEPTH - 1);

   logic [RAM_AW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = run && (cnt_q == LAST);

endmodule

// File: rtl/m6810_ram_arbiter.sv
// Shares the scratch RAM port between the CPU (combinational priority) and a host port
// (grant cycle G, ack and read data in G+1); zero-fills the RAM after reset or clr_req.
module m6810_ram_arbiter #(
   parameter int STARVE_LIMIT = 15,
   parameter int RAM_DEPTH    = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_req,
   input  logic [6:0] cpu_address,
   input  logic       cpu_cs,
   input  logic       cpu_rw,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_wait,
   input  logic       host_req,
   input  logic       host_rw,
   input  logic [6:0] host_address,
   input  logic [7:0] host_wdata,
   output logic       host_ack,
   output logic [7:0] host_rdata,
   output logic       busy,
   output logic [6:0] ram_address,
   output logic       ram_cs,
   output logic       ram_rw,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata
);

   import robotron_snd_pkg::*;

   arb_state_e state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] host_rdata_q, host_rdata_d;
   logic       host_grant;
   logic       clr_run;
   logic       clr_done;
   logic [6:0] clr_cnt;

   ram_clear_seq #(
      .DEPTH (RAM_DEPTH)
   ) u_clear_seq (
      .clk   (clk),
      .rst   (rst),
      .start (clr_req),
      .run   (clr_run),
      .cnt   (clr_cnt),
      .done  (clr_done)
   );

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      host_rdata_d = host_rdata_q;
      host_grant   = 1'b0;
      clr_run      = 1'b0;
      ram_cs       = 1'b0;
      ram_rw       = 1'b1;
      ram_address  = cpu_address;
      ram_wdata    = cpu_wdata;
      cpu_rdata    = ram_rdata;

      case (state_q)
         CLEAR: begin
            ram_cs      = 1'b1;
            ram_rw      = 1'b0;
            ram_address = clr_cnt;
            ram_wdata   = 8'h00;
            cpu_rdata   = 8'h00;
            clr_run     = 1'b1;
            if (clr_done) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (cpu_cs) begin
               ram_cs = 1'b1;
               ram_rw = cpu_rw;
            end else if (host_req && !clr_req) begin
               // A clear in the same cycle wins, so the host never touches the RAM here.
               host_grant  = 1'b1;
               ram_cs      = 1'b1;
               ram_rw      = host_rw;
               ram_address = host_address;
               ram_wdata   = host_wdata;
               if (host_rw) begin
                  host_rdata_d = ram_rdata;
               end
               state_d = ACK;
            end
         end
         ACK: begin
            if (cpu_cs) begin
               ram_cs = 1'b1;
               ram_rw = cpu_rw;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase

      if (!host_req || host_grant) begin
         wait_cnt_d = '0;
      end else if (state_q == IDLE && wait_cnt_q != 4'hF) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end

      if (clr_req) begin
         state_d = CLEAR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CLEAR;
         wait_cnt_q   <= '0;
         host_rdata_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   assign busy       = (state_q == CLEAR);
   assign host_ack   = (state_q == ACK);
   assign host_rdata = host_rdata_q;
   // Advisory only: the CPU keeps priority even while this is raised.
   assign cpu_wait   = (state_q == CLEAR) ||
                       ((state_q == IDLE) && (int'(wait_cnt_q) >= STARVE_LIMIT));

endmodule

// File: tb/tb_m6810_ram_arbiter.sv
// Randomised bench for m6810_ram_arbiter with a RAM model and a rule-level reference.
module tb_m6810_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr_req;
   logic [6:0] cpu_address;
   logic       cpu_cs;
   logic       cpu_rw;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_wait;
   logic       host_req;
   logic       host_rw;
   logic [6:0] host_address;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic [7:0] host_rdata;
   logic       busy;
   logic [6:0] ram_address;
   logic       ram_cs;
   logic       ram_rw;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [128];
   int         wr_seen = 0;
   int         ack_seen = 0;

   // Reference model state
   logic [7:0] ref_mem [128];
   int         clr_left;
   bit         ack_due;
   int         starve;
   logic [7:0] exp_hrd;

   always #5 clk = ~clk;

   m6810_ram_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .clr_req      (clr_req),
      .cpu_address  (cpu_address),
      .cpu_cs       (cpu_cs),
      .cpu_rw       (cpu_rw),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_wait     (cpu_wait),
      .host_req     (host_req),
      .host_rw      (host_rw),
      .host_address (host_address),
      .host_wdata   (host_wdata),
      .host_ack     (host_ack),
      .host_rdata   (host_rdata),
      .busy         (busy),
      .ram_address  (ram_address),
      .ram_cs       (ram_cs),
      .ram_rw       (ram_rw),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   assign ram_rdata = mem[ram_address];

   always @(posedge clk) begin
      if (host_ack) ack_seen <= ack_seen + 1;
      if (ram_cs && !ram_rw) begin
         mem[ram_address] <= ram_wdata;
         wr_seen <= wr_seen + 1;
      end
   end

   // Applies one clock of the arbitration rules to the reference model.
   task automatic tick();
      bit ack_now;
      bit idle_now;
      bit granted;
      granted = 0;
      if (rst) begin
         clr_left = 128; ack_due = 0; starve = 0; exp_hrd = 8'h00;
         return;
      end
      ack_now  = ack_due;
      idle_now = (clr_left == 0) && !ack_now;
      ack_due  = 0;
      if (clr_left > 0) begin
         ref_mem[128 - clr_left] = 8'h00;
         clr_left--;
      end else if (cpu_cs) begin
         if (!cpu_rw) ref_mem[cpu_address] = cpu_wdata;
      end else if (host_req && !ack_now && !clr_req) begin
         granted = 1;
         if (host_rw) exp_hrd = ref_mem[host_address];
         else ref_mem[host_address] = host_wdata;
         ack_due = 1;
      end
      if (!host_req || granted) starve = 0;
      else if (idle_now && starve < 15) starve++;
      if (clr_req) begin
         clr_left = 128;
         ack_due  = 0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; clr_req = 1'b0;
      cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_address = 7'h45; cpu_wdata = 8'h00;
      host_req = 1'b0; host_rw = 1'b0; host_address = 7'h00; host_wdata = 8'h00;
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
      repeat (3) cyc();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
      checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL reset_cpu_wait got=%b exp=1", cpu_wait); end
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack got=%b exp=0", host_ack); end
      checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata got=%h exp=00", host_rdata); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
      rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         cpu_cs = 1'($urandom); cpu_rw = 1'($urandom);
         cpu_address = 7'($urandom); cpu_wdata = 8'($urandom | 1);
         #1;
         checks++;
         if ({ram_cs, ram_rw, ram_address, ram_wdata, busy, cpu_rdata} !== {1'b1, 1'b0, 7'(i), 8'h00, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL clear_write[%0d] got cs=%b rw=%b a=%h d=%h busy=%b crd=%h exp cs=1 rw=0 a=%h d=00 busy=1 crd=00",
                     i, ram_cs, ram_rw, ram_address, ram_wdata, busy, cpu_rdata, 7'(i));
         end
         cyc();
      end
      cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_address = 7'h45;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy got=%b exp=0", busy); end
      checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL clear_done_wait got=%b exp=0", cpu_wait); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL read_45 got=%h exp=00", cpu_rdata); end
      cyc();
      cpu_cs = 1'b0;
   endtask

   task automatic test_cpu();
      logic [6:0] a;
      logic [7:0] d;
      for (int k = 0; k < 16; k++) begin
         a = (k == 0) ? 7'h10 : 7'($urandom_range(0, 127));
         d = (k == 0) ? 8'h5A : 8'($urandom);
         cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_address = a; cpu_wdata = d;
         cyc();
         cpu_rw = 1'b1;
         #1;
         checks++;
         if ({cpu_rdata, cpu_wait} !== {ref_mem[a], 1'b0}) begin
            errors++;
            $display("FAIL cpu_readback a=%h got=%h wait=%b exp=%h wait=0", a, cpu_rdata, cpu_wait, ref_mem[a]);
         end
         cyc();
      end
      cpu_cs = 1'b0;
      cyc();
   endtask

   task automatic test_host();
      logic [6:0] a;
      logic [7:0] d;
      bit         rw;
      bit         exp_ack;
      bit         got;
      for (int k = 0; k < 12; k++) begin
         a  = (k < 2) ? 7'h7F : 7'($urandom_range(0, 127));
         d  = (k == 0) ? 8'hC3 : 8'($urandom);
         rw = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom);
         host_req = 1'b1; host_rw = rw; host_address = a; host_wdata = d;
         got = 0;
         for (int t = 0; t < 40 && !got; t++) begin
            cpu_cs = (k < 2) ? 1'b0 : 1'($urandom);
            cpu_rw = 1'b1; cpu_address = 7'($urandom);
            exp_ack = !cpu_cs && !ack_due && clr_left == 0;
            cyc();
            checks++;
            if (host_ack !== exp_ack) begin
               errors++;
               $display("FAIL host_ack_timing op=%0d t=%0d got=%b exp=%b", k, t, host_ack, exp_ack);
            end
            if (host_ack) got = 1;
         end
         checks++;
         if (!got) begin errors++; $display("FAIL host_ack_timeout op=%0d got=none exp=ack", k); end
         if (rw) begin
            checks++;
            if (host_rdata !== exp_hrd) begin
               errors++;
               $display("FAIL host_rdata op=%0d got=%h exp=%h", k, host_rdata, exp_hrd);
            end
         end
         if (k == 1) begin
            checks++;
            if (host_rdata !== 8'hC3) begin errors++; $display("FAIL host_read_7f got=%h exp=c3", host_rdata); end
         end
         host_req = 1'b0; cpu_cs = 1'b0;
      end
      cyc();
   endtask

   task automatic test_starve();
      logic [6:0] a;
      logic [7:0] d;
      a = 7'($urandom); d = 8'($urandom);
      host_req = 1'b1; host_rw = 1'b0; host_address = a; host_wdata = d;
      cpu_cs = 1'b1; cpu_rw = 1'b1;
      for (int n = 0; n < 20; n++) begin
         cpu_address = (a == 7'd0) ? 7'd1 : a - 7'd1;
         #1;
         checks++;
         if ({cpu_wait, host_ack, ram_rw} !== {(n >= 15), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL starve n=%0d got wait=%b ack=%b rw=%b exp wait=%b ack=0 rw=1",
                     n, cpu_wait, host_ack, ram_rw, (n >= 15));
         end
         cyc();
      end
      cpu_cs = 1'b0;
      #1;
      checks++;
      if ({ram_cs, ram_rw, ram_address, ram_wdata} !== {1'b1, 1'b0, a, d}) begin
         errors++;
         $display("FAIL starve_grant got cs=%b rw=%b a=%h d=%h exp cs=1 rw=0 a=%h d=%h",
                  ram_cs, ram_rw, ram_address, ram_wdata, a, d);
      end
      cyc();
      checks++;
      if ({host_ack, cpu_wait} !== 2'b10) begin
         errors++;
         $display("FAIL starve_release got ack=%b wait=%b exp ack=1 wait=0", host_ack, cpu_wait);
      end
      host_req = 1'b0;
      cyc();
      checks++;
      if (mem[a] !== d) begin errors++; $display("FAIL starve_write a=%h got=%h exp=%h", a, mem[a], d); end
   endtask

   task automatic test_clr();
      logic [6:0] a;
      logic [7:0] d;
      int         n;
      int         bad;
      for (int k = 0; k < 8; k++) begin
         cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_address = 7'($urandom); cpu_wdata = 8'($urandom | 1);
         cyc();
      end
      cpu_cs = 1'b0;
      a = 7'($urandom); d = 8'($urandom | 1);
      host_req = 1'b1; host_rw = 1'b0; host_address = a; host_wdata = d;
      clr_req = 1'b1;
      #1;
      checks++;
      if (ram_cs !== 1'b0) begin errors++; $display("FAIL clr_beats_grant ram_cs got=%b exp=0", ram_cs); end
      cyc();
      clr_req = 1'b0;
      for (int i = 0; i < 50; i++) begin
         checks++;
         if ({busy, host_ack} !== 2'b10) begin
            errors++;
            $display("FAIL clr_hold[%0d] got busy=%b ack=%b exp busy=1 ack=0", i, busy, host_ack);
         end
         cyc();
      end
      checks++;
      if (ram_address !== 7'd50) begin errors++; $display("FAIL clr_at_50 got=%h exp=32", ram_address); end
      clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      checks++;
      if (ram_address !== 7'd0) begin errors++; $display("FAIL clr_restart got=%h exp=00", ram_address); end
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         if (host_ack !== 1'b0) begin
            checks++; errors++;
            $display("FAIL clr_no_ack n=%0d got=1 exp=0", n);
         end
         n++;
         cyc();
      end
      checks++;
      if (n != 128) begin errors++; $display("FAIL clr_busy_len got=%0d exp=128", n); end
      #1;
      checks++;
      if ({ram_cs, ram_rw, ram_address} !== {1'b1, 1'b0, a}) begin
         errors++;
         $display("FAIL held_host_grant got cs=%b rw=%b a=%h exp cs=1 rw=0 a=%h", ram_cs, ram_rw, ram_address, a);
      end
      cyc();
      checks++;
      if (host_ack !== 1'b1) begin errors++; $display("FAIL held_host_ack got=%b exp=1", host_ack); end
      host_req = 1'b0;
      cyc();
      bad = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ((7'(i) == a) ? d : 8'h00)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clr_contents bad_words=%0d exp=0", bad); end
   endtask

   task automatic test_back_to_back();
      int         wr0;
      int         ack0;
      logic [6:0] a [4];
      logic [7:0] d [4];
      int         bad;
      wr0 = wr_seen; ack0 = ack_seen;
      cpu_cs = 1'b0;
      host_req = 1'b1; host_rw = 1'b0; host_address = 7'($urandom); host_wdata = 8'($urandom);
      cyc();
      checks++;
      if (host_ack !== 1'b1) begin errors++; $display("FAIL hold_ack got=%b exp=1", host_ack); end
      cyc();
      host_req = 1'b0;
      checks++;
      if (host_ack !== 1'b0) begin errors++; $display("FAIL hold_single_pulse got=%b exp=0", host_ack); end
      cyc();
      checks++;
      if ({wr_seen - wr0, ack_seen - ack0} !== {32'd1, 32'd1}) begin
         errors++;
         $display("FAIL hold_counts got writes=%0d acks=%0d exp writes=1 acks=1", wr_seen - wr0, ack_seen - ack0);
      end
      for (int j = 0; j < 4; j++) begin
         a[j] = 7'(j * 29 + 3); d[j] = 8'($urandom);
         host_req = 1'b1; host_rw = 1'b0; host_address = a[j]; host_wdata = d[j];
         if (j > 0) begin
            cyc();
            checks++;
            if (host_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d] got=%b exp=0", j, host_ack); end
         end
         cyc();
         checks++;
         if (host_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=1", j, host_ack); end
      end
      host_req = 1'b0;
      cyc();
      bad = 0;
      for (int j = 0; j < 4; j++) if (mem[a[j]] !== d[j] || ref_mem[a[j]] !== d[j]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_contents bad_words=%0d exp=0", bad); end
      bad = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL model_contents bad_words=%0d exp=0", bad); end
   endtask

   initial begin
      test_reset();
      test_cpu();
      test_host();
      test_starve();
      test_clr();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
